// File: rtl/rtc_write_sequencer.sv
// Walks local registers through the RTC data mux and writes each byte to the RTC as an
// address phase followed by a data phase. Define RTC_TIMER_WR_EN to also write timer registers 7..9.
module rtc_write_sequencer #(
    parameter int T_PULSE = 4,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dato_mem_local,
    output logic [3:0] addr_mem_local,
    output logic       reg_wr,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       busy,
    output logic       done
);

`ifdef RTC_TIMER_WR_EN
    localparam logic [3:0] LAST = 4'd9;
`else
    localparam logic [3:0] LAST = 4'd6;
`endif
    localparam logic [3:0] PULSE_CNT = 4'(T_PULSE);
    localparam logic [3:0] GAP_CNT   = 4'(T_GAP);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ADDR_SETUP, S_ADDR_WR, S_ADDR_HOLD,
        S_DATA_SETUP, S_DATA_WR, S_DATA_HOLD, S_NEXT, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       reg_wr_q, reg_wr_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       rd_n_q, rd_n_d;
    logic       a_d_q, a_d_d;
    logic       ad_oe_q, ad_oe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h27;
            4'd7:    return 8'h41;
            4'd8:    return 8'h42;
            4'd9:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    // Every output is decoded on the transition into a state, so its register lines up with that state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ad_out_d = ad_out_q;
        reg_wr_d = reg_wr_q;
        cs_n_d   = cs_n_q;
        wr_n_d   = wr_n_q;
        rd_n_d   = 1'b1;
        a_d_d    = a_d_q;
        ad_oe_d  = ad_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    cnt_d    = 4'd2;
                    idx_d    = 4'd0;
                    addr_d   = 4'd0;
                    reg_wr_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_LOAD: begin
                // Mux output is registered: byte is valid on the second edge after the address change.
                if (cnt_q == 4'd1) begin
                    data_d   = dato_mem_local;
                    state_d  = S_ADDR_SETUP;
                    cnt_d    = 4'd1;
                    cs_n_d   = 1'b0;
                    a_d_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = rtc_addr(idx_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ADDR_SETUP: begin
                state_d = S_ADDR_WR;
                cnt_d   = PULSE_CNT;
                wr_n_d  = 1'b0;
            end
            S_ADDR_WR: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_ADDR_HOLD;
                    cnt_d   = GAP_CNT;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ADDR_HOLD: begin
                if (cnt_q == 4'd1) begin
                    state_d  = S_DATA_SETUP;
                    cnt_d    = 4'd1;
                    a_d_d    = 1'b1;
                    ad_out_d = data_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DATA_SETUP: begin
                state_d = S_DATA_WR;
                cnt_d   = PULSE_CNT;
                wr_n_d  = 1'b0;
            end
            S_DATA_WR: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_DATA_HOLD;
                    cnt_d   = GAP_CNT;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DATA_HOLD: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_NEXT;
                    cnt_d   = 4'd1;
                    cs_n_d  = 1'b1;
                    ad_oe_d = 1'b0;
                    a_d_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = 4'd1;
                    done_d   = 1'b1;
                    reg_wr_d = 1'b1;
                    busy_d   = 1'b0;
                    addr_d   = 4'd0;
                end else begin
                    state_d = S_LOAD;
                    cnt_d   = 4'd2;
                    idx_d   = idx_q + 4'd1;
                    addr_d  = idx_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= 4'd0;
            addr_q   <= 4'd0;
            ad_out_q <= 8'h00;
            reg_wr_q <= 1'b1;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            a_d_q    <= 1'b0;
            ad_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            ad_out_q <= ad_out_d;
            reg_wr_q <= reg_wr_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            a_d_q    <= a_d_d;
            ad_oe_q  <= ad_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign addr_mem_local = addr_q;
    assign reg_wr         = reg_wr_q;
    assign cs_n           = cs_n_q;
    assign wr_n           = wr_n_q;
    assign rd_n           = rd_n_q;
    assign a_d            = a_d_q;
    assign ad_out         = ad_out_q;
    assign ad_oe          = ad_oe_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: default-timing instance plus a T_PULSE=1/T_GAP=1 instance.
module tb_rtc_write_sequencer;

`ifdef RTC_TIMER_WR_EN
    localparam int N = 10;
`else
    localparam int N = 7;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start  [2];
    logic [7:0] mux    [2];
    logic [3:0] addr   [2];
    logic       reg_wr [2];
    logic       cs_n   [2];
    logic       wr_n   [2];
    logic       rd_n   [2];
    logic       a_d    [2];
    logic [7:0] ad_out [2];
    logic       ad_oe  [2];
    logic       busy   [2];
    logic       done   [2];

    logic [7:0] map_t [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
    logic [7:0] base_t [2] = '{8'h10, 8'h30};
    int         tp_t   [2] = '{4, 1};
    int         cpr_t  [2] = '{17, 9};

    logic [8:0] exp_q[$];
    int         exp_lat;
    int         st_cyc;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         ndone [2] = '{0, 0};
    int         falls [2] = '{0, 0};
    int         low_len [2] = '{0, 0};
    logic       prev_wr [2] = '{1'b1, 1'b1};
    logic       prev_ad [2] = '{1'b0, 1'b0};
    logic [8:0] lat_bus [2] = '{9'h0, 9'h0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_write_sequencer dut0 (
        .clk(clk), .reset(rst), .start(start[0]), .dato_mem_local(mux[0]),
        .addr_mem_local(addr[0]), .reg_wr(reg_wr[0]), .cs_n(cs_n[0]), .wr_n(wr_n[0]),
        .rd_n(rd_n[0]), .a_d(a_d[0]), .ad_out(ad_out[0]), .ad_oe(ad_oe[0]),
        .busy(busy[0]), .done(done[0])
    );

    rtc_write_sequencer #(.T_PULSE(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(rst), .start(start[1]), .dato_mem_local(mux[1]),
        .addr_mem_local(addr[1]), .reg_wr(reg_wr[1]), .cs_n(cs_n[1]), .wr_n(wr_n[1]),
        .rd_n(rd_n[1]), .a_d(a_d[1]), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Registered mux model: byte follows the address one edge later, forced to 0 while reg_wr=1.
    always @(posedge clk) begin
        mux[0] <= reg_wr[0] ? 8'h00 : base_t[0] + {4'h0, addr[0]};
        mux[1] <= reg_wr[1] ? 8'h00 : base_t[1] + {4'h0, addr[1]};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected {a_d, ad_out} pair on every wr_n falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_wr[d] = 1'b1;
                prev_ad[d] = 1'b0;
                low_len[d] = 0;
            end else begin
                if (!wr_n[d]) begin
                    if (prev_wr[d]) begin
                        falls[d]++;
                        check("a_d_steady_at_fall", 32'(a_d[d]), 32'(prev_ad[d]));
                        check("cs_oe_at_fall", 32'({cs_n[d], ad_oe[d]}), 32'h1);
                        if (exp_q.size() == 0)
                            check("unexpected_write", 32'({a_d[d], ad_out[d]}), 32'h1ff);
                        else
                            check("bus_pair", 32'({a_d[d], ad_out[d]}), 32'(exp_q.pop_front()));
                        lat_bus[d] = {a_d[d], ad_out[d]};
                        low_len[d] = 0;
                    end
                    low_len[d]++;
                end else if (!prev_wr[d]) begin
                    check("wr_low_len", 32'(low_len[d]), 32'(tp_t[d]));
                    check("bus_stable_hold", 32'({a_d[d], ad_out[d]}), 32'(lat_bus[d]));
                end
                if (done[d]) begin
                    ndone[d]++;
                    check("done_latency", 32'(cyc - st_cyc), 32'(exp_lat));
                    check("sb_empty_at_done", 32'(exp_q.size()), 32'h0);
                end
                prev_wr[d] = wr_n[d];
                prev_ad[d] = a_d[d];
            end
        end
    end

    task automatic issue(input int d);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({1'b0, map_t[i]});
            exp_q.push_back({1'b1, base_t[d] + 8'(i)});
        end
        exp_lat = N * cpr_t[d];
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_cs_n"},   32'(cs_n[d]),   32'h1);
        check({tag, "_wr_n"},   32'(wr_n[d]),   32'h1);
        check({tag, "_rd_n"},   32'(rd_n[d]),   32'h1);
        check({tag, "_ad_oe"},  32'(ad_oe[d]),  32'h0);
        check({tag, "_busy"},   32'(busy[d]),   32'h0);
        check({tag, "_done"},   32'(done[d]),   32'h0);
        check({tag, "_reg_wr"}, 32'(reg_wr[d]), 32'h1);
        check({tag, "_addr"},   32'(addr[d]),   32'h0);
    endtask

    task automatic run(input int d, input int lim);
        int n0;
        int f0;
        int off;
        n0 = ndone[d];
        f0 = falls[d];
        issue(d);
        check("busy_after_start", 32'(busy[d]), 32'h1);
        while (cyc - st_cyc < lim) begin
            off = cyc - st_cyc;
            // Extra starts mid-run, one cycle before done and in the done cycle must all be ignored.
            start[d] = (off == 5 || off == 50 || off == exp_lat - 1 || off == exp_lat);
            @(negedge clk);
        end
        start[d] = 1'b0;
        repeat (3) @(negedge clk);
        check("done_count", 32'(ndone[d] - n0), 32'h1);
        check("wr_fall_count", 32'(falls[d] - f0), 32'(2 * N));
        check("sb_empty_end", 32'(exp_q.size()), 32'h0);
        check_idle(d, "post_run");
    endtask

    initial begin
        logic hit;
        int   n0;
        rst = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        check("rst_a_d", 32'(a_d[0]), 32'h0);
        check("rst_ad_out", 32'(ad_out[0]), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(0, N * 17 + 20);
        run(1, N * 9 + 20);

        // Abort during the data-phase strobe of index 4.
        issue(0);
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            hit = (addr[0] == 4'd4) && a_d[0] && !wr_n[0];
        end
        check("reached_data_wr_idx4", 32'(hit), 32'h1);
        n0 = ndone[0];
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle(0, "abort");
        check("abort_ad_out", 32'(ad_out[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (N * 17 + 10) @(negedge clk);
        check("no_done_after_abort", 32'(ndone[0] - n0), 32'h0);
        check_idle(0, "after_abort");

        run(0, N * 17 + 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
